// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: parses 0xCC,A,B,FUN frames from a byte stream, runs the ALU
// and returns the result LSB-first over ready/valid. Optional macro ALU_CMD_REUSE_EN adds 0xDD,FUN.
module alu_cmd_ctrl #(
  parameter int OP_W  = 8,
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [OP_W-1:0]  alu_a,
  output logic [OP_W-1:0]  alu_b,
  output logic [3:0]       alu_fun,
  output logic             alu_en,
  output logic             alu_clk_en,
  input  logic [RES_W-1:0] alu_out,
  input  logic             alu_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             err
);

  localparam int NBYTES = RES_W / 8;
  localparam int CW     = $clog2(NBYTES) + 1;

  localparam logic [7:0] HDR_FULL  = 8'hCC;
  localparam logic [7:0] HDR_REUSE = 8'hDD;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GET_A   = 3'd1;
  localparam logic [2:0] GET_B   = 3'd2;
  localparam logic [2:0] GET_FUN = 3'd3;
  localparam logic [2:0] EXEC    = 3'd4;
  localparam logic [2:0] CAPTURE = 3'd5;
  localparam logic [2:0] SEND_LO = 3'd6;
  localparam logic [2:0] SEND_HI = 3'd7;

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [RES_W-1:0] res_rest;
  logic [CW-1:0]    bytes_left;
  logic             exec_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == HDR_FULL) begin
            state_nx = GET_A;
          end
`ifdef ALU_CMD_REUSE_EN
          else if (rx_data == HDR_REUSE) begin
            state_nx = GET_FUN;
          end
`endif
        end
      end
      GET_A:   if (rx_valid) state_nx = GET_B;
      GET_B:   if (rx_valid) state_nx = GET_FUN;
      GET_FUN: if (rx_valid) state_nx = EXEC;
      EXEC:    state_nx = CAPTURE;
      CAPTURE: state_nx = alu_valid ? SEND_LO : IDLE;
      // SEND_HI covers every byte after the first; bytes_left counts those still queued
      SEND_LO, SEND_HI: begin
        if (tx_ready) state_nx = (bytes_left != '0) ? SEND_HI : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign exec_nx = (state_nx == EXEC) || (state_nx == CAPTURE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fun    <= '0;
      alu_en     <= 1'b0;
      alu_clk_en <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      err        <= 1'b0;
      res_rest   <= '0;
      bytes_left <= '0;
    end else begin
      state      <= state_nx;
      alu_en     <= exec_nx;
      alu_clk_en <= exec_nx;
      err        <= (state == CAPTURE) && !alu_valid;
      case (state)
        GET_A:   if (rx_valid) alu_a   <= OP_W'(rx_data);
        GET_B:   if (rx_valid) alu_b   <= OP_W'(rx_data);
        GET_FUN: if (rx_valid) alu_fun <= rx_data[3:0];
        CAPTURE: begin
          if (alu_valid) begin
            tx_data    <= alu_out[7:0];
            res_rest   <= alu_out >> 8;
            bytes_left <= CW'(NBYTES - 1);
            tx_valid   <= 1'b1;
          end
        end
        SEND_LO, SEND_HI: begin
          if (tx_ready) begin
            if (bytes_left != '0) begin
              tx_data    <= res_rest[7:0];
              res_rest   <= res_rest >> 8;
              bytes_left <= bytes_left - CW'(1);
            end else begin
              tx_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
